// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// Redirect sources are encoded so that a larger value means a higher priority.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_J    = 3'd1,
        SRC_JR   = 3'd2,
        SRC_BR   = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } src_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int unsigned DEF_PC_INC       = 4;

    // Low 28 bits of a j/jal target; the upper bits come from the ID-stage PC+4.
    function automatic logic [27:0] jump_low(input logic [25:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select among N {valid, source, target} candidates.
// Ties go to the lowest index, so callers place the incumbent entry first.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned N      = 5,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [N-1:0]      req_valid,
    input  src_t              req_src    [N],
    input  logic [ADDR_W-1:0] req_target [N],
    output logic              sel_valid,
    output src_t              sel_src,
    output logic [ADDR_W-1:0] sel_target
);

    always_comb begin
        sel_valid  = 1'b0;
        sel_src    = SRC_SEQ;
        sel_target = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_valid[i] && (!sel_valid || (req_src[i] > sel_src))) begin
                sel_valid  = 1'b1;
                sel_src    = req_src[i];
                sel_target = req_target[i];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage with EPC and a stall-safe redirect buffer.
// Optional macro PC_PERF_EN adds saturating redirect/stall performance counters.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
    parameter int unsigned       PC_INC       = DEF_PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              eret,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              j_valid,
    input  logic [25:0]       j_index,
    input  logic [ADDR_W-1:0] id_pcplus4,
`ifdef PC_PERF_EN
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic              redirect_pending,
    output logic              misalign_err
);

    logic              pend_valid;
    src_t              pend_src;
    logic [ADDR_W-1:0] pend_target;

    logic [ADDR_W-1:0] j_tgt;
    logic [4:0]        l_valid;
    src_t              l_src [5];
    logic [ADDR_W-1:0] l_tgt [5];
    logic              live_valid;
    src_t              live_src;
    logic [ADDR_W-1:0] live_target;

    logic [1:0]        m_in_valid;
    src_t              m_in_src [2];
    logic [ADDR_W-1:0] m_in_tgt [2];
    logic              m_valid;
    src_t              m_src;
    logic [ADDR_W-1:0] m_target;

    always_comb begin
        j_tgt       = id_pcplus4;
        j_tgt[27:0] = jump_low(j_index);
        l_valid     = {j_valid, jr_valid, br_taken, eret, exc_req};
        l_src[0]    = SRC_EXC;
        l_src[1]    = SRC_ERET;
        l_src[2]    = SRC_BR;
        l_src[3]    = SRC_JR;
        l_src[4]    = SRC_J;
        l_tgt[0]    = EXC_VECTOR;
        l_tgt[1]    = epc;
        l_tgt[2]    = br_target;
        l_tgt[3]    = jr_target;
        l_tgt[4]    = j_tgt;
    end

    pc_redirect_arb #(.N(5), .ADDR_W(ADDR_W)) u_live_arb (
        .req_valid  (l_valid),
        .req_src    (l_src),
        .req_target (l_tgt),
        .sel_valid  (live_valid),
        .sel_src    (live_src),
        .sel_target (live_target)
    );

    // Buffered entry sits at index 0 so an equal-priority live redirect never displaces it.
    always_comb begin
        m_in_valid  = {live_valid, pend_valid};
        m_in_src[0] = pend_src;
        m_in_src[1] = live_src;
        m_in_tgt[0] = pend_target;
        m_in_tgt[1] = live_target;
    end

    pc_redirect_arb #(.N(2), .ADDR_W(ADDR_W)) u_merge_arb (
        .req_valid  (m_in_valid),
        .req_src    (m_in_src),
        .req_target (m_in_tgt),
        .sel_valid  (m_valid),
        .sel_src    (m_src),
        .sel_target (m_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_VECTOR;
            epc          <= '0;
            pend_valid   <= 1'b0;
            pend_src     <= SRC_SEQ;
            pend_target  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (exc_req) begin
                pc           <= {EXC_VECTOR[ADDR_W-1:2], 2'b00};
                misalign_err <= |EXC_VECTOR[1:0];
                epc          <= exc_pc;
                pend_valid   <= 1'b0;
            end else if (stall) begin
                pend_valid  <= m_valid;
                pend_src    <= m_src;
                pend_target <= m_target;
            end else begin
                pend_valid <= 1'b0;
                if (m_valid) begin
                    pc           <= {m_target[ADDR_W-1:2], 2'b00};
                    misalign_err <= |m_target[1:0];
                end else begin
                    pc <= pc + ADDR_W'(PC_INC);
                end
            end
        end
    end

    assign redirect_pending = pend_valid;

`ifdef PC_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_redirect_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if ((exc_req || (!stall && m_valid)) && (perf_redirect_cnt != '1))
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            if (stall && !exc_req && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
